// File: rtl/usr_write_gather_if.sv
// Host write window, transport command and sector payload signals for usr_write_gather.
// The slave modport is the gather block; master is the host/transport side.
interface usr_write_gather_if;
  logic        INT_WR_EN;
  logic [56:0] ADDRESS_IN;
  logic [31:0] DATA_IN;
  logic        WR_HOLD_OUT;
  logic        WR_DONE;
  logic        WR_OVERFLOW;
  logic        CMD_REQ;
  logic [47:0] CMD_LBA;
  logic [15:0] CMD_SECTORS;
  logic        CMD_ACK;
  logic [31:0] TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        XFER_DONE;

  modport slave (
    input  INT_WR_EN, ADDRESS_IN, DATA_IN, CMD_ACK, TX_READY, XFER_DONE,
    output WR_HOLD_OUT, WR_DONE, WR_OVERFLOW, CMD_REQ, CMD_LBA, CMD_SECTORS,
           TX_DATA, TX_VALID
  );

  modport master (
    output INT_WR_EN, ADDRESS_IN, DATA_IN, CMD_ACK, TX_READY, XFER_DONE,
    input  WR_HOLD_OUT, WR_DONE, WR_OVERFLOW, CMD_REQ, CMD_LBA, CMD_SECTORS,
           TX_DATA, TX_VALID
  );
endinterface

// File: rtl/usr_write_gather.sv
// Gathers host word writes into whole sectors, then issues one single-sector
// write command per completed sector and streams its payload to the transport layer.
module usr_write_gather #(
  parameter int SECTOR_WORDS = 128,
  parameter int FIFO_WORDS   = 256
) (
  input  logic              USR_CLOCK,
  input  logic              USR_RESET_N,
  usr_write_gather_if.slave bus
);
  localparam int AW = $clog2(FIFO_WORDS);
  localparam int OW = $clog2(SECTOR_WORDS);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_WORDS);
  localparam logic [AW:0]   HOLD_TH  = (AW+1)'(FIFO_WORDS - SECTOR_WORDS);
  localparam logic [OW-1:0] OFF_LAST = OW'(SECTOR_WORDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_addr;
  logic [AW:0]   count_reg, count_next;
  logic [OW-1:0] offset_reg, tx_cnt_reg;
  logic [1:0]    sect_cnt_reg, sect_cnt_next;
  logic [47:0]   lba_q_reg [2];
  logic          lba_wr_reg, lba_rd_reg;
  logic          hold_reg, done_reg, ovf_reg;
  logic [15:0]   sectors_reg;
  logic [31:0]   mem [FIFO_WORDS];
  logic [31:0]   rd_data_reg;

  logic accept, pop, wrap, last_tx, done_evt, lba_push, lba_pop;
  logic unused_addr_bits;

  assign unused_addr_bits = ^bus.ADDRESS_IN[8:0];

  assign accept   = bus.INT_WR_EN && (count_reg < DEPTH);
  assign pop      = (state_reg == ST_XFER) && bus.TX_READY;
  assign wrap     = accept && (offset_reg == OFF_LAST);
  assign last_tx  = pop && (tx_cnt_reg == OFF_LAST);
  assign done_evt = (state_reg == ST_WAIT) && bus.XFER_DONE;
  assign lba_push = accept && (offset_reg == '0);
  assign lba_pop  = (state_reg == ST_CMD) && bus.CMD_ACK;
  assign rd_addr  = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

  // The read register re-reads the head every cycle, so a word fetched in the
  // same cycle it was written is refreshed before it can ever be presented.
  always_ff @(posedge USR_CLOCK) begin
    if (accept)
      mem[wr_ptr_reg] <= bus.DATA_IN;
    rd_data_reg <= mem[rd_addr];
  end

  always_comb begin
    count_next = count_reg;
    if (accept && !pop)
      count_next = count_reg + 1'b1;
    else if (!accept && pop)
      count_next = count_reg - 1'b1;
  end

  always_comb begin
    sect_cnt_next = sect_cnt_reg;
    if (wrap && !done_evt)
      sect_cnt_next = sect_cnt_reg + 2'd1;
    else if (!wrap && done_evt)
      sect_cnt_next = sect_cnt_reg - 2'd1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (sect_cnt_reg != 2'd0) state_next = ST_CMD;
      ST_CMD:  if (bus.CMD_ACK)          state_next = ST_XFER;
      ST_XFER: if (last_tx)              state_next = ST_WAIT;
      ST_WAIT: if (bus.XFER_DONE)        state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge USR_CLOCK or negedge USR_RESET_N) begin
    if (!USR_RESET_N) begin
      state_reg    <= ST_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      offset_reg   <= '0;
      tx_cnt_reg   <= '0;
      sect_cnt_reg <= '0;
      lba_wr_reg   <= 1'b0;
      lba_rd_reg   <= 1'b0;
      hold_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      sectors_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      sect_cnt_reg <= sect_cnt_next;
      hold_reg     <= (count_next > HOLD_TH);
      sectors_reg  <= 16'd1;
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        offset_reg <= offset_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        tx_cnt_reg <= tx_cnt_reg + 1'b1;
      end else if (lba_pop) begin
        tx_cnt_reg <= '0;
      end
      if (lba_push)
        lba_wr_reg <= ~lba_wr_reg;
      if (lba_pop)
        lba_rd_reg <= ~lba_rd_reg;
      if (bus.INT_WR_EN && !accept)
        ovf_reg <= 1'b1;
      // Done only when the last committed sector leaves nothing behind, not
      // even a sector that starts in this very cycle.
      if (done_evt && (sect_cnt_reg == 2'd1) && !accept && (offset_reg == '0))
        done_reg <= 1'b1;
      else if (accept)
        done_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lba
    always_ff @(posedge USR_CLOCK or negedge USR_RESET_N) begin
      if (!USR_RESET_N)
        lba_q_reg[gi] <= '0;
      else if (lba_push && (lba_wr_reg == 1'(gi)))
        lba_q_reg[gi] <= bus.ADDRESS_IN[56:9];
    end
  end

  assign bus.WR_HOLD_OUT = hold_reg;
  assign bus.WR_DONE     = done_reg;
  assign bus.WR_OVERFLOW = ovf_reg;
  assign bus.CMD_REQ     = (state_reg == ST_CMD);
  assign bus.CMD_LBA     = (state_reg == ST_CMD) ? lba_q_reg[lba_rd_reg] : '0;
  assign bus.CMD_SECTORS = sectors_reg;
  assign bus.TX_VALID    = (state_reg == ST_XFER);
  assign bus.TX_DATA     = (state_reg == ST_XFER) ? rd_data_reg : '0;
endmodule

// File: tb/tb_usr_write_gather.sv
// Directed bench for usr_write_gather: a vector table for fill-level outcomes
// plus hand-written sequences for command, transfer, stall and reset corners.
module tb_usr_write_gather;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  usr_write_gather_if bus();

  usr_write_gather #(.SECTOR_WORDS(128), .FIFO_WORDS(256)) dut (
    .USR_CLOCK   (clk),
    .USR_RESET_N (rst_n),
    .bus         (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int tb_fill = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          n_wr;
    logic [47:0] lba;
    bit          req;
    logic [47:0] lba_o;
    bit          hold;
    bit          ovf;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.INT_WR_EN  = 1'b0;
    bus.ADDRESS_IN = '0;
    bus.DATA_IN    = '0;
    bus.CMD_ACK    = 1'b0;
    bus.TX_READY   = 1'b0;
    bus.XFER_DONE  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    tb_fill = 0;
  endtask

  task automatic write_words(input logic [47:0] lba, input int first, input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      bus.INT_WR_EN  = 1'b1;
      bus.ADDRESS_IN = {lba, 9'h0} + 57'(4 * (first + i));
      bus.DATA_IN    = d;
      if (tb_fill < 256) begin
        exp_q.push_back(d);
        tb_fill++;
      end
      @(posedge clk);
      #1;
    end
    bus.INT_WR_EN = 1'b0;
  endtask

  task automatic wait_cmd(input logic [47:0] exp_lba, input string tag, input int delay);
    bit found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (bus.CMD_REQ) found = 1'b1;
    end
    check({tag, " cmd_req"}, 64'(found), 64'd1);
    if (found) begin
      check({tag, " cmd_lba"}, 64'(bus.CMD_LBA), 64'(exp_lba));
      check({tag, " cmd_sectors"}, 64'(bus.CMD_SECTORS), 64'd1);
      if (delay > 0) begin
        bus.XFER_DONE = 1'b1;
        repeat (delay) @(negedge clk);
        bus.XFER_DONE = 1'b0;
        #1;
        check({tag, " cmd_hold"}, 64'({bus.CMD_REQ, bus.CMD_LBA}), 64'({1'b1, exp_lba}));
      end
      bus.CMD_ACK = 1'b1;
      $display("cmd %s lba=0x%0h", tag, exp_lba);
    end
  endtask

  task automatic rx(input int n_hs, input bit toggle, input string tag);
    int          got = 0;
    bit          prev_stall = 1'b0;
    bit          ph = 1'b1;
    logic [31:0] prev = '0;
    logic [63:0] e;
    for (int cyc = 0; cyc < 2000 && got < n_hs; cyc++) begin
      @(negedge clk);
      bus.CMD_ACK = 1'b0;
      if (toggle) begin
        bus.TX_READY = ph;
        ph = ~ph;
      end else begin
        bus.TX_READY = 1'b1;
      end
      #1;
      if (prev_stall) check({tag, " stall_data"}, 64'(bus.TX_DATA), 64'(prev));
      prev_stall = bus.TX_VALID && !bus.TX_READY;
      prev       = bus.TX_DATA;
      if (bus.TX_VALID && bus.TX_READY) begin
        e = (exp_q.size() > 0) ? 64'(exp_q.pop_front()) : 64'hFFFF_FFFF_0000_0000;
        check({tag, " tx_data"}, 64'(bus.TX_DATA), e);
        got++;
        tb_fill--;
      end
    end
    check({tag, " handshakes"}, 64'(got), 64'(n_hs));
    $display("xfer %s handshakes=%0d", tag, got);
  endtask

  task automatic finish_sector(input bit exp_done, input string tag);
    @(negedge clk);
    #1;
    check({tag, " valid_drop"}, 64'(bus.TX_VALID), 64'd0);
    bus.XFER_DONE = 1'b1;
    @(negedge clk);
    bus.XFER_DONE = 1'b0;
    #1;
    check({tag, " wr_done"}, 64'(bus.WR_DONE), 64'(exp_done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0,   48'h0,            1'b0, 48'h0,            1'b0, 1'b0};
    vecs[1] = '{64,  48'h5,            1'b0, 48'h0,            1'b0, 1'b0};
    vecs[2] = '{128, 48'h9,            1'b1, 48'h9,            1'b0, 1'b0};
    vecs[3] = '{129, 48'h1234,         1'b1, 48'h1234,         1'b1, 1'b0};
    vecs[4] = '{256, 48'hABCDE,        1'b1, 48'hABCDE,        1'b1, 1'b0};
    vecs[5] = '{257, 48'hFFFF_FFFF_FFF0, 1'b1, 48'hFFFF_FFFF_FFF0, 1'b1, 1'b1};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      if (vecs[v].n_wr > 0)
        write_words(vecs[v].lba, 0, (vecs[v].n_wr > 128) ? 128 : vecs[v].n_wr);
      if (vecs[v].n_wr > 128)
        write_words(48'(vecs[v].lba + 1), 0, vecs[v].n_wr - 128);
      repeat (3) @(negedge clk);
      #1;
      check($sformatf("vec%0d cmd_req", v), 64'(bus.CMD_REQ), 64'(vecs[v].req));
      check($sformatf("vec%0d cmd_lba", v), 64'(bus.CMD_LBA), 64'(vecs[v].lba_o));
      check($sformatf("vec%0d cmd_sectors", v), 64'(bus.CMD_SECTORS), 64'd1);
      check($sformatf("vec%0d hold", v), 64'(bus.WR_HOLD_OUT), 64'(vecs[v].hold));
      check($sformatf("vec%0d overflow", v), 64'(bus.WR_OVERFLOW), 64'(vecs[v].ovf));
      check($sformatf("vec%0d wr_done", v), 64'(bus.WR_DONE), 64'd0);
      check($sformatf("vec%0d tx_valid", v), 64'(bus.TX_VALID), 64'd0);
      $display("vector %0d writes=%0d", v, vecs[v].n_wr);
    end

    // Basic sector at LBA 9, with ignored XFER_DONE pulses while the command waits.
    do_reset();
    write_words(48'h9, 0, 128);
    wait_cmd(48'h9, "A", 3);
    rx(128, 1'b0, "A");
    finish_sector(1'b1, "A");

    // Next write clears WR_DONE; transfer with TX_READY toggling.
    write_words(48'h77, 0, 128);
    check("D wr_done_clear", 64'(bus.WR_DONE), 64'd0);
    wait_cmd(48'h77, "D", 0);
    rx(128, 1'b1, "D");
    finish_sector(1'b1, "D");

    // Full FIFO plus one dropped write, then drain both sectors.
    do_reset();
    write_words(48'h20, 0, 128);
    write_words(48'h21, 0, 129);
    #1;
    check("C overflow", 64'(bus.WR_OVERFLOW), 64'd1);
    check("C hold", 64'(bus.WR_HOLD_OUT), 64'd1);
    wait_cmd(48'h20, "C1", 0);
    rx(128, 1'b0, "C1");
    finish_sector(1'b0, "C1");
    check("C hold_release", 64'(bus.WR_HOLD_OUT), 64'd0);
    wait_cmd(48'h21, "C2", 0);
    rx(128, 1'b0, "C2");
    finish_sector(1'b1, "C2");
    check("C overflow_sticky", 64'(bus.WR_OVERFLOW), 64'd1);

    // Second sector completes in the same cycle as XFER_DONE of the first.
    do_reset();
    write_words(48'h10, 0, 128);
    write_words(48'h11, 0, 127);
    wait_cmd(48'h10, "E1", 0);
    rx(128, 1'b0, "E1");
    @(negedge clk);
    #1;
    check("E1 valid_drop", 64'(bus.TX_VALID), 64'd0);
    bus.INT_WR_EN  = 1'b1;
    bus.ADDRESS_IN = {48'h11, 9'h0} + 57'd508;
    bus.DATA_IN    = 32'hC0DE_0127;
    exp_q.push_back(32'hC0DE_0127);
    bus.XFER_DONE  = 1'b1;
    @(negedge clk);
    bus.INT_WR_EN  = 1'b0;
    bus.XFER_DONE  = 1'b0;
    #1;
    check("E wr_done_low", 64'(bus.WR_DONE), 64'd0);
    wait_cmd(48'h11, "E2", 0);
    rx(128, 1'b0, "E2");
    finish_sector(1'b1, "E2");
    repeat (4) @(negedge clk);
    check("E no_extra_cmd", 64'(bus.CMD_REQ), 64'd0);

    // Reset in the middle of a transfer, then a clean sector.
    do_reset();
    write_words(48'h30, 0, 128);
    wait_cmd(48'h30, "F", 0);
    rx(60, 1'b0, "F");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("F rst_flags", 64'({bus.WR_HOLD_OUT, bus.WR_DONE, bus.WR_OVERFLOW, bus.CMD_REQ, bus.TX_VALID}), 64'd0);
    check("F rst_lba", 64'(bus.CMD_LBA), 64'd0);
    check("F rst_sectors", 64'(bus.CMD_SECTORS), 64'd0);
    check("F rst_txdata", 64'(bus.TX_DATA), 64'd0);
    do_reset();
    write_words(48'h31, 0, 128);
    wait_cmd(48'h31, "F2", 0);
    rx(128, 1'b0, "F2");
    finish_sector(1'b1, "F2");

    // Partial sector is held back, including across a stray XFER_DONE in IDLE.
    do_reset();
    write_words(48'h40, 0, 64);
    @(negedge clk);
    bus.XFER_DONE = 1'b1;
    @(negedge clk);
    bus.XFER_DONE = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("G partial_no_cmd", 64'(bus.CMD_REQ), 64'd0);
    check("G partial_wr_done", 64'(bus.WR_DONE), 64'd0);
    write_words(48'h40, 64, 64);
    wait_cmd(48'h40, "G", 0);
    rx(128, 1'b0, "G");
    finish_sector(1'b1, "G");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
